// File: rtl/lzc_norm_iter.sv
// Iterative leading-zero counter and normaliser.
// Examines CHUNK bits per clock starting from the MSB chunk, then reports the
// leading-zero count, an all-zero flag and the word shifted so that its first
// '1' lands on the MSB. Ready/valid on both sides; one word in flight at a time.
module lzc_norm_iter #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  localparam int ZW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ZW-1:0]    out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = $clog2(NCH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg;
  logic [ZW-1:0]      count_reg;
  logic [CW-1:0]      chunks_left_reg;

  logic [CHUNK-1:0]   top_chunk;
  logic               top_zero;
  logic [ZW-1:0]      lead;
  logic [WIDTH-1:0]   shifted_chunk;
  logic               accept;
  logic               last_chunk;

  assign top_chunk  = shift_reg[WIDTH-1 -: CHUNK];
  assign top_zero   = ~|top_chunk;
  assign accept     = in_valid && in_ready;
  assign last_chunk = (chunks_left_reg == CW'(1));

  // A whole-chunk shift only exists when there is more than one chunk; with a
  // single chunk the word is either resolved or all-zero on the first scan edge.
  generate
    if (NCH > 1) begin : g_multi
      assign shifted_chunk = {shift_reg[WIDTH-CHUNK-1:0], {CHUNK{1'b0}}};
    end else begin : g_single
      assign shifted_chunk = '0;
    end
  endgenerate

  // Priority encoder: leading zeros within the top chunk (highest set bit wins).
  always_comb begin
    lead = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (top_chunk[i]) lead = ZW'(CHUNK - 1 - i);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (!top_zero || last_chunk) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is held low while the block is in reset.
  always_comb begin
    in_ready  = rst_n && (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  // Datapath: load on accept, walk chunks in SCAN, capture the result on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg       <= '0;
      count_reg       <= '0;
      chunks_left_reg <= '0;
      out_count       <= '0;
      out_zero        <= 1'b0;
      out_norm        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shift_reg       <= in_data;
            count_reg       <= '0;
            chunks_left_reg <= CW'(NCH);
          end
        end
        SCAN: begin
          if (top_zero) begin
            if (!last_chunk) begin
              count_reg       <= count_reg + ZW'(CHUNK);
              shift_reg       <= shifted_chunk;
              chunks_left_reg <= chunks_left_reg - CW'(1);
            end else begin
              out_count <= ZW'(WIDTH);
              out_zero  <= 1'b1;
              out_norm  <= '0;
            end
          end else begin
            out_count <= count_reg + lead;
            out_zero  <= 1'b0;
            out_norm  <= shift_reg << lead;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_norm_iter.sv
// Bench for lzc_norm_iter: directed table and hand-written corner sequences on
// a 16/4 instance, plus a parameter sweep (8/1, 8/8 exhaustive, 32/4 random)
// checked against a plain leading-zero model.
module tb_lzc_norm_iter;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: count zeros from the MSB of a w-bit word, normalise by shifting.
  task automatic model(input logic [31:0] d, input int w, output int lz, output logic [31:0] norm);
    logic [31:0] mask;
    lz = w;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i]) begin
        lz = w - 1 - i;
        break;
      end
    end
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    norm = (lz == w) ? 32'd0 : ((d << lz) & mask);
  endtask

  // ---------------- main 16/4 instance ----------------
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [15:0] in_data, out_norm;
  logic [4:0]  out_count;

  lzc_norm_iter #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_zero(out_zero), .out_norm(out_norm)
  );

  typedef struct {
    logic [15:0] data;
    int          count;
    logic        zero;
    logic [15:0] norm;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[10];

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run16(input logic [15:0] d, input int hold, input int ec, input logic ez,
                       input logic [15:0] en, input int el, input string tag);
    int lat;
    @(negedge clk);
    in_data = d; in_valid = 1'b1; out_ready = (hold == 0);
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 16'($urandom);
    check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_count"}, 32'(out_count), 32'(ec));
    check({tag, "_zero"}, 32'(out_zero), 32'(ez));
    check({tag, "_norm"}, 32'(out_norm), 32'(en));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_count"}, 32'(out_count), 32'(ec));
      check({tag, "_hold_norm"}, 32'(out_norm), 32'(en));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    $display("[TB] 16/4 %s data=%04h count=%0d zero=%0d norm=%04h lat=%0d",
             tag, d, out_count, out_zero, out_norm, lat);
  endtask

  // ---------------- parameter sweep instances ----------------
  logic [2:0] sweep_done;

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    localparam int W  = (gi == 2) ? 32 : 8;
    localparam int C  = (gi == 0) ? 1 : ((gi == 1) ? 8 : 4);
    localparam int SZ = $clog2(W + 1);

    logic          s_rst_n, s_valid, s_iready, s_ovalid, s_oready, s_zero, done;
    logic [W-1:0]  s_data, s_norm;
    logic [SZ-1:0] s_count;

    assign sweep_done[gi] = done;

    lzc_norm_iter #(.WIDTH(W), .CHUNK(C)) dut_s (
      .clk(clk), .rst_n(s_rst_n), .in_valid(s_valid), .in_ready(s_iready),
      .in_data(s_data), .out_valid(s_ovalid), .out_ready(s_oready),
      .out_count(s_count), .out_zero(s_zero), .out_norm(s_norm)
    );

    task automatic run(input logic [W-1:0] d);
      int lz, lat, el;
      logic [31:0] en;
      model(32'(d), W, lz, en);
      el = (lz == W) ? W / C : lz / C + 1;
      @(negedge clk);
      s_data = d; s_valid = 1'b1; s_oready = 1'b1;
      check($sformatf("sweep%0d_in_ready", gi), 32'(s_iready), 32'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data = W'($urandom);
      lat = 0;
      while (!s_ovalid && lat < 2 * W + 8) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("sweep%0d_latency", gi), 32'(lat), 32'(el));
      check($sformatf("sweep%0d_count", gi), 32'(s_count), 32'(lz));
      check($sformatf("sweep%0d_zero", gi), 32'(s_zero), 32'(lz == W));
      check($sformatf("sweep%0d_norm", gi), 32'(s_norm), en);
      @(posedge clk); #1;
      check($sformatf("sweep%0d_valid_drop", gi), 32'(s_ovalid), 32'd0);
      $display("[TB] %0d/%0d data=%0h count=%0d zero=%0d norm=%0h lat=%0d",
               W, C, d, s_count, s_zero, s_norm, lat);
    endtask

    initial begin
      logic [W-1:0] r;
      done = 1'b0;
      s_rst_n = 1'b0; s_valid = 1'b0; s_oready = 1'b0; s_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) s_rst_n = 1'b1;
      if (W == 8) begin
        for (int n = 0; n < 256; n++) run(W'(n));
      end else begin
        run('0);
        run({1'b1, {(W-1){1'b0}}});
        run(W'(1));
        for (int n = 0; n < 150; n++) begin
          r = W'($urandom);
          r = r >> $urandom_range(0, W);
          run(r);
        end
      end
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int lz, lat;
    logic [31:0] en;
    logic [15:0] r;

    vecs[0] = '{16'h8000,  0, 1'b0, 16'h8000, 1, 0};
    vecs[1] = '{16'h00F0,  8, 1'b0, 16'hF000, 3, 0};
    vecs[2] = '{16'h0001, 15, 1'b0, 16'h8000, 4, 0};
    vecs[3] = '{16'h0000, 16, 1'b1, 16'h0000, 4, 0};
    vecs[4] = '{16'h4000,  1, 1'b0, 16'h8000, 1, 2};
    vecs[5] = '{16'h1234,  3, 1'b0, 16'h91A0, 1, 0};
    vecs[6] = '{16'h0010, 11, 1'b0, 16'h8000, 3, 1};
    vecs[7] = '{16'h7FFF,  1, 1'b0, 16'hFFFE, 1, 0};
    vecs[8] = '{16'h0800,  4, 1'b0, 16'h8000, 2, 0};
    vecs[9] = '{16'h0300,  6, 1'b0, 16'hC000, 2, 3};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_count", 32'(out_count), 32'd0);
    check("reset_zero", 32'(out_zero), 32'd0);
    check("reset_norm", 32'(out_norm), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i])
      run16(vecs[i].data, vecs[i].hold, vecs[i].count, vecs[i].zero, vecs[i].norm,
            vecs[i].lat, $sformatf("vec%0d", i));

    // Backpressure with a competing word presented during SCAN/DONE.
    @(negedge clk);
    in_data = 16'h0300; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 16'h0001;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_count", 32'(out_count), 32'd6);
      check("bp_norm", 32'(out_norm), 32'hC000);
      check("bp_zero", 32'(out_zero), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_second_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_second_latency", 32'(lat), 32'd4);
    check("bp_second_count", 32'(out_count), 32'd15);
    @(posedge clk); #1;
    check("bp_second_drop", 32'(out_valid), 32'd0);
    $display("[TB] 16/4 backpressure 0300 then 0001 done");

    // Reset in the middle of a scan.
    @(negedge clk);
    in_data = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_count", 32'(out_count), 32'd0);
    check("midrst_zero", 32'(out_zero), 32'd0);
    check("midrst_norm", 32'(out_norm), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("midrst_release_in_ready", 32'(in_ready), 32'd1);
    check("midrst_release_valid", 32'(out_valid), 32'd0);
    $display("[TB] 16/4 reset mid-scan done");
    run16(16'h4000, 0, 1, 1'b0, 16'h8000, 1, "after_rst");

    // Random words with random backpressure.
    for (int n = 0; n < 120; n++) begin
      r = 16'($urandom);
      r = r >> $urandom_range(0, 16);
      model(32'(r), 16, lz, en);
      run16(r, $urandom_range(0, 2), lz, lz == 16, en[15:0],
            (lz == 16) ? 4 : lz / 4 + 1, $sformatf("rnd%0d", n));
    end

    for (int k = 0; k < 20000 && sweep_done != 3'b111; k++) @(posedge clk);
    check("sweep_done", 32'(sweep_done), 32'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lzc_norm_iter.md
Name: lzc_norm_iter

Overview:
- Parametrised, iterative leading-zero counter and normaliser for WIDTH-bit words.
- Scans CHUNK bits per clock, MSB chunk first.
- Returns the leading-zero count, an all-zero flag, and the input shifted left so its first '1' sits at the MSB.
- Sits between switch/datapath sources and display/arithmetic sinks; ready/valid on both sides.

Parameters:
- WIDTH, 16, input word width; must be a multiple of CHUNK and at least 2.
- CHUNK, 4, bits examined per scan cycle; 1 ≤ CHUNK ≤ WIDTH.
- ZW (localparam), $clog2(WIDTH+1), width of the count output.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  word to scan.
- out_valid  out  1  result registers are valid.
- out_ready  in  1  sink accepts the result.
- out_count  out  ZW  number of leading zeros, 0..WIDTH.
- out_zero  out  1  in_data was all zeros.
- out_norm  out  WIDTH  in_data << out_count; 0 when out_zero.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0, out_count=0, out_zero=0, out_norm=0; internal shift register, count and chunk counter cleared. in_ready is forced to 0 while rst_n is low.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load shift register with in_data, count=0, chunks_left=WIDTH/CHUNK; go to SCAN.
- SCAN (in_ready=0, out_valid=0). Each edge examines the top CHUNK bits of the shift register:
  - Top chunk all zero and chunks_left>1: count+=CHUNK, shift left by CHUNK, chunks_left−1, stay in SCAN.
  - Top chunk all zero and chunks_left==1: count=WIDTH, out_zero=1, out_norm=0; go to DONE.
  - Top chunk non-zero: p = leading zeros within the chunk (priority encode, 0..CHUNK−1). out_count=count+p, out_norm=shift register<<p, out_zero=0; go to DONE.
- Latency:
  - First '1' in chunk index j (0 = MSB chunk): out_valid rises j+1 edges after the accepting edge.
  - All-zero word: out_valid rises WIDTH/CHUNK edges after the accepting edge.
  - Data-dependent, no fixed pipeline.
- DONE:
  - out_valid=1; out_count, out_zero and out_norm are held stable while out_ready=0.
  - On out_ready: out_valid drops on that edge and the FSM returns to IDLE.
  - in_ready stays 0 in DONE, so there is no overlap. Maximum throughput is one word per (scan cycles + 2) cycles.
- Width rules:
  - count arithmetic is done in ZW bits and never exceeds WIDTH.
  - Shifts are logical; vacated LSBs fill with 0.
- Boundary conditions:
  - in_valid asserted in SCAN/DONE: ignored; the source holds the word until in_ready.
  - in_data changes after acceptance: no effect on the result.
  - CHUNK==WIDTH: every word completes in 1 scan edge.
  - CHUNK==1: bit-serial operation.
  - out_ready high before out_valid: no effect; the result is still presented for at least one cycle.
  - rst_n asserted mid-SCAN or mid-DONE: the operation is abandoned; out_valid drops immediately (asynchronously) and no partial result is ever presented.
  - Deassertion of rst_n is synchronised externally; after release, the block is in IDLE with in_ready=1 on the first edge.

Test Plan:
- WIDTH=16, CHUNK=4, in_data=0x8000, out_ready=1 → out_valid 1 edge after accept; count=0, zero=0, norm=0x8000; back in IDLE next edge.
- in_data=0x00F0 → out_valid 3 edges after accept; count=8, norm=0xF000, zero=0.
- in_data=0x0001 → 4 edges; count=15, norm=0x8000. in_data=0x0000 → 4 edges; count=16, zero=1, norm=0x0000.
- Backpressure: in_data=0x0300, hold out_ready=0 for 5 cycles → out_valid, count=6 and norm=0xC000 stable throughout; in_ready=0; a second in_valid is not accepted until one edge after out_ready rises.
- Reset mid-scan: accept 0x0001, pull rst_n low after 2 edges → out_valid=0 and all outputs 0 immediately. After release, in_ready=1; 0x4000 yields count=1 after 1 edge.
- Parameter sweep (WIDTH=8, CHUNK=1), (WIDTH=8, CHUNK=8) and (WIDTH=32, CHUNK=4): exhaustive for WIDTH=8, random for 32. Compare count/zero/norm against a behavioural model and latency against the j+1 rule.
